// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Merges the cpu instruction-fetch port and data port onto one
//               shared memory bus with a ready handshake. Data requests win
//               by default; a starvation counter forces an instruction grant
//               after STARVE_LIMIT consecutive data grants with fetch waiting.
//               A single transaction is outstanding at any time.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  // instruction port
  input  logic [63:0] instr_address_in,
  input  logic        instr_read_in,
  output logic [63:0] instr_read_value_out,
  output logic        instr_ready_out,
  // data port
  input  logic [63:0] data_address_in,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [6:0]  data_write_mask_in,
  input  logic [63:0] data_write_value_in,
  output logic [63:0] data_read_value_out,
  output logic        data_ready_out,
  // shared memory bus
  output logic [63:0] mem_address_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [6:0]  mem_write_mask_out,
  output logic [63:0] mem_write_value_out,
  input  logic [63:0] mem_read_value_in,
  input  logic        mem_ready_in
);

  localparam int              CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_I = 2'd1;
  localparam logic [1:0] GRANT_D = 2'd2;

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [CNT_W-1:0] starve_cnt;
  logic             data_req;
  logic             force_instr;
  logic             grant_d;
  logic             grant_i;
  logic             done;

  // Arbitration inputs: fetch is forced only when it has been starved long enough
  always_comb begin
    data_req    = data_read_in | data_write_in;
    force_instr = instr_read_in && (starve_cnt == STARVE_MAX);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: data wins unless fetch is being forced; grants end on mem ready
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (data_req && !force_instr) begin
          next_state = GRANT_D;
        end else if (instr_read_in) begin
          next_state = GRANT_I;
        end
      end
      GRANT_I, GRANT_D: begin
        if (mem_ready_in) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output logic: ready pulses are combinational from the bus; read data passes through
  always_comb begin
    grant_d              = (state == IDLE) && (next_state == GRANT_D);
    grant_i              = (state == IDLE) && (next_state == GRANT_I);
    done                 = (state != IDLE) && mem_ready_in;
    instr_ready_out      = (state == GRANT_I) && mem_ready_in;
    data_ready_out       = (state == GRANT_D) && mem_ready_in;
    instr_read_value_out = mem_read_value_in;
    data_read_value_out  = mem_read_value_in;
  end

  // Starvation counter: counts data grants taken while fetch was waiting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_d) begin
      if (instr_read_in) begin
        starve_cnt <= (starve_cnt == STARVE_MAX) ? STARVE_MAX : starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end else if (grant_i) begin
      starve_cnt <= '0;
    end
  end

  // Bus registers: latch the winner on grant, hold during the grant, drop strobes on completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_address_out     <= '0;
      mem_read_out        <= 1'b0;
      mem_write_out       <= 1'b0;
      mem_write_mask_out  <= '0;
      mem_write_value_out <= '0;
    end else if (grant_d) begin
      mem_address_out     <= data_address_in;
      mem_read_out        <= data_read_in;
      mem_write_out       <= data_write_in;
      mem_write_mask_out  <= data_write_mask_in;
      mem_write_value_out <= data_write_value_in;
    end else if (grant_i) begin
      mem_address_out     <= instr_address_in;
      mem_read_out        <= 1'b1;
      mem_write_out       <= 1'b0;
      mem_write_mask_out  <= '0;
      mem_write_value_out <= '0;
    end else if (done) begin
      mem_read_out        <= 1'b0;
      mem_write_out       <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Randomized scoreboard bench for mem_bus_arbiter. A transaction
//               level model decides grants from the arbitration rules and
//               plays the memory side; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  localparam int LIMIT  = 4;
  localparam int CYCLES = 600;

  typedef struct {
    bit          is_data;
    logic [63:0] addr;
    bit          rd;
    bit          wr;
    logic [6:0]  mask;
    logic [63:0] wval;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] instr_address_in;
  logic        instr_read_in;
  logic [63:0] instr_read_value_out;
  logic        instr_ready_out;
  logic [63:0] data_address_in;
  logic        data_read_in;
  logic        data_write_in;
  logic [6:0]  data_write_mask_in;
  logic [63:0] data_write_value_in;
  logic [63:0] data_read_value_out;
  logic        data_ready_out;
  logic [63:0] mem_address_out;
  logic        mem_read_out;
  logic        mem_write_out;
  logic [6:0]  mem_write_mask_out;
  logic [63:0] mem_write_value_out;
  logic [63:0] mem_read_value_in;
  logic        mem_ready_in;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk                  (clk),
    .reset                (reset),
    .instr_address_in     (instr_address_in),
    .instr_read_in        (instr_read_in),
    .instr_read_value_out (instr_read_value_out),
    .instr_ready_out      (instr_ready_out),
    .data_address_in      (data_address_in),
    .data_read_in         (data_read_in),
    .data_write_in        (data_write_in),
    .data_write_mask_in   (data_write_mask_in),
    .data_write_value_in  (data_write_value_in),
    .data_read_value_out  (data_read_value_out),
    .data_ready_out       (data_ready_out),
    .mem_address_out      (mem_address_out),
    .mem_read_out         (mem_read_out),
    .mem_write_out        (mem_write_out),
    .mem_write_mask_out   (mem_write_mask_out),
    .mem_write_value_out  (mem_write_value_out),
    .mem_read_value_in    (mem_read_value_in),
    .mem_ready_in         (mem_ready_in)
  );

  int          checks = 0;
  int          fails  = 0;
  txn_t        exp_q[$];
  logic [63:0] rval_q[$];
  bit          busy   = 1'b0;
  int          lat    = 0;
  int          starve = 0;
  int          rst_seq = 0;
  int          rst_count = 0;
  bit          drain  = 1'b0;
  bit          starve_phase = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] r64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic clear_requests();
    instr_read_in       = 1'b0;
    data_read_in        = 1'b0;
    data_write_in       = 1'b0;
    instr_address_in    = r64();
    data_address_in     = r64();
    data_write_mask_in  = 7'($urandom());
    data_write_value_in = r64();
  endtask

  // Transaction-level model: one bus transaction at a time, judged at each rising edge
  task automatic model_edge();
    txn_t t;
    if (reset) return;
    if (busy) begin
      if (mem_ready_in) busy = 1'b0;
      else lat--;
    end else if ((data_read_in || data_write_in) && !(instr_read_in && starve == LIMIT)) begin
      t.is_data = 1'b1;
      t.addr    = data_address_in;
      t.rd      = data_read_in;
      t.wr      = data_write_in;
      t.mask    = data_write_mask_in;
      t.wval    = data_write_value_in;
      exp_q.push_back(t);
      starve = instr_read_in ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
      busy   = 1'b1;
      lat    = $urandom_range(0, 3);
    end else if (instr_read_in) begin
      t.is_data = 1'b0;
      t.addr    = instr_address_in;
      t.rd      = 1'b1;
      t.wr      = 1'b0;
      t.mask    = '0;
      t.wval    = '0;
      exp_q.push_back(t);
      starve = 0;
      busy   = 1'b1;
      lat    = $urandom_range(0, 3);
    end
  endtask

  task automatic drive();
    int op;
    mem_read_value_in = r64();
    if (busy) begin
      mem_ready_in = (lat == 0);
      if (mem_ready_in) rval_q.push_back(mem_read_value_in);
    end else begin
      mem_ready_in = ($urandom_range(0, 3) == 0);
    end
    clear_requests();
    if (drain) return;
    if (starve_phase) begin
      instr_read_in = 1'b1;
      data_read_in  = 1'b1;
    end else begin
      instr_read_in = ($urandom_range(0, 3) != 0);
      op            = $urandom_range(0, 4);
      data_read_in  = (op == 1) || (op == 3);
      data_write_in = (op == 2) || (op == 3) || (op == 4);
    end
  endtask

  task automatic check_bus_idle(input string tag);
    check({tag, "_mem_addr"},  mem_address_out, 64'd0);
    check({tag, "_mem_read"},  {63'd0, mem_read_out}, 64'd0);
    check({tag, "_mem_write"}, {63'd0, mem_write_out}, 64'd0);
    check({tag, "_mem_mask"},  {57'd0, mem_write_mask_out}, 64'd0);
    check({tag, "_mem_wval"},  mem_write_value_out, 64'd0);
    check({tag, "_rdy_i"},     {63'd0, instr_ready_out}, 64'd0);
    check({tag, "_rdy_d"},     {63'd0, data_ready_out}, 64'd0);
  endtask

  // Monitor: compares the bus against the pending transaction and pops on each ready pulse
  txn_t        mon_e;
  logic [63:0] mon_rv;
  always @(negedge clk) begin
    if (!reset) begin
      check("ready_exclusive", {63'd0, instr_ready_out & data_ready_out}, 64'd0);
      check("strobe_vs_busy", {63'd0, mem_read_out | mem_write_out}, {63'd0, busy});
      if (busy && exp_q.size() > 0) begin
        mon_e = exp_q[0];
        check("bus_addr",  mem_address_out, mon_e.addr);
        check("bus_read",  {63'd0, mem_read_out},  {63'd0, mon_e.rd});
        check("bus_write", {63'd0, mem_write_out}, {63'd0, mon_e.wr});
        if (mon_e.is_data) begin
          check("bus_mask", {57'd0, mem_write_mask_out}, {57'd0, mon_e.mask});
          check("bus_wval", mem_write_value_out, mon_e.wval);
        end
      end
      if (instr_ready_out || data_ready_out) begin
        if (exp_q.size() == 0 || rval_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_ready actual=i%0b/d%0b expected=no pulse t=%0t",
                   instr_ready_out, data_ready_out, $time);
        end else begin
          mon_e  = exp_q.pop_front();
          mon_rv = rval_q.pop_front();
          check("ready_kind", {63'd0, data_ready_out}, {63'd0, mon_e.is_data});
          if (mon_e.is_data) check("data_rvalue", data_read_value_out, mon_rv);
          else               check("instr_rvalue", instr_read_value_out, mon_rv);
        end
      end
    end
  end

  initial begin
    reset             = 1'b1;
    mem_ready_in      = 1'b0;
    mem_read_value_in = '0;
    clear_requests();
    repeat (2) @(posedge clk);
    #1;
    check_bus_idle("reset");
    reset = 1'b0;

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(posedge clk);
      model_edge();
      #1;
      starve_phase = (cyc < 60);
      drain        = (cyc >= CYCLES - 20);
      if (rst_seq > 0) begin
        // Reset held, then released with a stray bus ready that must be ignored
        clear_requests();
        mem_ready_in = 1'b1;
        if (rst_seq == 2) reset = 1'b0;
        rst_seq--;
      end else if (!drain && rst_count < 3 && cyc >= 200 + rst_count * 120 && busy && lat >= 1) begin
        clear_requests();
        mem_ready_in = 1'b0;
        reset        = 1'b1;
        #1;
        check_bus_idle("midop_reset");
        busy   = 1'b0;
        starve = 0;
        exp_q.delete();
        rval_q.delete();
        rst_seq = 3;
        rst_count++;
      end else begin
        drive();
      end
    end

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
